// File: rtl/gearbox_stream_arbiter.sv
// rtl/gearbox_stream_arbiter.sv - round-robin packet arbiter pacing a shared unpacking gearbox
// Optional stall abort of a granted packet is enabled by defining GBARB_TIMEOUT_EN.
module gearbox_stream_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int IN_WIDTH       = 32,
   parameter int OUT_WIDTH      = 7,
   parameter int GB_CAPACITY    = 38,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*IN_WIDTH-1:0]      req_data,
   input  logic [NUM_REQ-1:0]               req_last,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             gb_valid_in,
   output logic [IN_WIDTH-1:0]              gb_data_in,
   output logic                             gb_flush,
   output logic [$clog2(NUM_REQ)-1:0]       active_id,
   output logic                             busy,
   output logic [$clog2(GB_CAPACITY+1)-1:0] fill_level,
   output logic                             err_timeout
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int FW  = $clog2(GB_CAPACITY + 1);
   localparam int XW  = FW + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;

   state_t         state_q;
   logic [IDW-1:0] active_q;
   logic [IDW-1:0] rr_q;
   logic [IDW-1:0] rr_d;
   logic [FW-1:0]  fill_q;

   logic           emit;
   logic           send_ok;
   logic           send;
   logic           timeout_hit;
   logic [XW-1:0]  fill_x;
   logic [XW-1:0]  after_emit;
   logic [XW-1:0]  fill_d;
   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   int             pos;

   // Fill arithmetic carries one spare bit so the capacity test cannot wrap.
   assign fill_x     = {1'b0, fill_q};
   assign emit       = fill_q >= FW'(OUT_WIDTH);
   assign after_emit = fill_x - (emit ? XW'(OUT_WIDTH) : '0);
   assign send_ok    = (after_emit + XW'(IN_WIDTH)) <= XW'(GB_CAPACITY);
   assign send       = (state_q == STREAM) && send_ok && req_valid[active_q];
   assign fill_d     = after_emit + (send ? XW'(IN_WIDTH) : '0);
   assign rr_d       = (active_q == IDW'(NUM_REQ - 1)) ? '0 : active_q + IDW'(1);

   always_comb begin
      req_ready = '0;
      if (state_q == STREAM && send_ok) begin
         req_ready[active_q] = 1'b1;
      end
   end

   assign gb_valid_in = send;
   assign gb_data_in  = send ? req_data[active_q*IN_WIDTH +: IN_WIDTH] : '0;
   assign gb_flush    = (state_q == FLUSH);
   assign busy        = (state_q != IDLE);
   assign active_id   = active_q;
   assign fill_level  = fill_q;

   // Cyclic search from rr_q; the nearest valid requester is written last and wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_q;
      pos         = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = int'(rr_q) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         if (req_valid[IDW'(pos)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(pos);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         active_q <= '0;
         rr_q     <= '0;
         fill_q   <= '0;
      end else begin
         fill_q <= FW'(fill_d);
         case (state_q)
            IDLE: begin
               if (grant_found) begin
                  active_q <= grant_idx;
                  state_q  <= STREAM;
               end
            end
            STREAM: begin
               if ((send && req_last[active_q]) || timeout_hit) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (after_emit < XW'(OUT_WIDTH)) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               fill_q  <= '0;
               rr_q    <= rr_d;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef GBARB_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SW-1:0] stall_q;
   logic          err_timeout_q;

   assign timeout_hit = (state_q == STREAM) && !req_valid[active_q]
                        && (stall_q == SW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q       <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         err_timeout_q <= timeout_hit;
         if (state_q != STREAM || send || timeout_hit) begin
            stall_q <= '0;
         end else if (!req_valid[active_q]) begin
            stall_q <= stall_q + SW'(1);
         end
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_stream_arbiter.sv
// tb/tb_gearbox_stream_arbiter.sv - self-checking bench for gearbox_stream_arbiter
`timescale 1ns/1ps
module tb_gearbox_stream_arbiter;

   localparam int N   = 4;
   localparam int IW  = 32;
   localparam int OW  = 7;
   localparam int CAP = 38;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*IW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            gb_valid_in;
   logic [IW-1:0]   gb_data_in;
   logic            gb_flush;
   logic [1:0]      active_id;
   logic            busy;
   logic [5:0]      fill_level;
   logic            err_timeout;

   always #5 clk = ~clk;

   gearbox_stream_arbiter #(
      .NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .GB_CAPACITY(CAP), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .gb_valid_in(gb_valid_in), .gb_data_in(gb_data_in),
      .gb_flush(gb_flush), .active_id(active_id), .busy(busy), .fill_level(fill_level),
      .err_timeout(err_timeout)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [N-1:0]  valid;
      logic [N-1:0]  last;
      logic [IW-1:0] data;
      logic [N-1:0]  e_ready;
      logic          e_gbv;
      logic          e_flush;
      logic          e_busy;
      logic [1:0]    e_act;
      logic [5:0]    e_fill;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                               input logic [3:0] r, input logic g, input logic f, input logic b,
                               input logic [1:0] a, input logic [5:0] fl);
      vec_t t;
      t.valid = v; t.last = l; t.data = d; t.e_ready = r; t.e_gbv = g;
      t.e_flush = f; t.e_busy = b; t.e_act = a; t.e_fill = fl;
      return t;
   endfunction

   // Reference model: pending words per requester, packet-level grant order, fill arithmetic.
   typedef struct {
      int          rid;
      logic [31:0] data;
      bit          last;
      int          delay;
   } word_t;

   word_t wq[$];
   int    gap[N];
   int    grants[$];
   int    acc_log[$];
   int    fill_m, owner, rr_m, pend_grant, pkts_done, cyc;
   bit    in_pkt, streaming, draining, exp_flush;

   function automatic int head_of(input int r);
      for (int k = 0; k < wq.size(); k++) begin
         if (wq[k].rid == r) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      fill_m = 0; owner = 0; rr_m = 0; pend_grant = -1;
      in_pkt = 0; streaming = 0; draining = 0; exp_flush = 0;
   endtask

   task automatic tick(input bit do_rst);
      int h, after, a, next_fill, cand;
      bit ok, idle_now;
      logic [N-1:0] exp_rdy, acc;
      @(negedge clk);
      cyc++;
      rst = do_rst;
      for (int i = 0; i < N; i++) begin
         h = head_of(i);
         if (h >= 0 && gap[i] >= wq[h].delay) begin
            req_valid[i] = 1'b1;
            req_last[i]  = wq[h].last;
            req_data[i*IW +: IW] = wq[h].data;
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'($urandom);
            req_data[i*IW +: IW] = $urandom;
            gap[i]++;
         end
      end
      #1;
      if (do_rst) begin
         model_reset();
         return;
      end
      if (pend_grant >= 0) begin
         chk("grant_id", active_id, pend_grant);
         owner = pend_grant;
         grants.push_back(owner);
         in_pkt = 1; streaming = 1; pend_grant = -1;
      end
      idle_now = !in_pkt;
      chk("busy", busy, in_pkt);
      chk("flush", gb_flush, exp_flush);
      chk("fill", fill_level, fill_m);
      chk("fill_max", fill_level <= CAP, 1);
      after   = fill_m - ((fill_m >= OW) ? OW : 0);
      ok      = (after + IW) <= CAP;
      exp_rdy = (streaming && ok) ? (N'(1) << owner) : '0;
      chk("ready", req_ready, exp_rdy);
      acc = req_valid & req_ready;
      chk("gb_valid", gb_valid_in, acc != 0);
      if (exp_flush) begin
         exp_flush = 0; in_pkt = 0; pkts_done++;
         rr_m = (owner + 1) % N;
         next_fill = 0;
      end else begin
         if (draining && after < OW) begin
            draining  = 0;
            exp_flush = 1;
         end
         next_fill = after + ((acc != 0) ? IW : 0);
      end
      if (acc != 0) begin
         a = 0;
         for (int i = 0; i < N; i++) if (acc[i]) a = i;
         chk("acc_owner", a, owner);
         h = head_of(a);
         chk("gb_data", gb_data_in, wq[h].data);
         acc_log.push_back(cyc);
         if (wq[h].last) begin
            streaming = 0;
            draining  = 1;
         end
         wq.delete(h);
         gap[a] = 0;
      end
      fill_m = next_fill;
      if (idle_now && req_valid != 0) begin
         for (int k = 0; k < N; k++) begin
            cand = (rr_m + k) % N;
            if (pend_grant < 0 && req_valid[cand]) pend_grant = cand;
         end
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((wq.size() != 0 || in_pkt || pend_grant >= 0 || exp_flush) && n < budget) begin
         tick(0);
         n++;
      end
      chk("idle_within_budget", n < budget, 1);
   endtask

   task automatic push(input int r, input logic [31:0] d, input bit l, input int dl);
      word_t w;
      w.rid = r; w.data = d; w.last = l; w.delay = dl;
      wq.push_back(w);
   endtask

   initial begin
      int n, base, npk, len;

      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 0, 2'd0, 6'd0));
      tv.push_back(mk(4'b0100, 4'b0100, 32'hDEADBEEF, 4'b0000, 0, 0, 0, 2'd0, 6'd0));
      tv.push_back(mk(4'b0100, 4'b0100, 32'hDEADBEEF, 4'b0100, 1, 0, 1, 2'd2, 6'd0));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd2, 6'd32));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd2, 6'd25));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd2, 6'd18));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd2, 6'd11));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 1, 1, 2'd2, 6'd4));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 0, 2'd2, 6'd0));
      tv.push_back(mk(4'b0001, 4'b0000, 32'h12345678, 4'b0000, 0, 0, 0, 2'd2, 6'd0));
      tv.push_back(mk(4'b0001, 4'b0000, 32'h12345678, 4'b0001, 1, 0, 1, 2'd0, 6'd0));
      tv.push_back(mk(4'b0001, 4'b1001, 32'hCAFEF00D, 4'b0000, 0, 0, 1, 2'd0, 6'd32));
      tv.push_back(mk(4'b0001, 4'b1001, 32'hCAFEF00D, 4'b0000, 0, 0, 1, 2'd0, 6'd25));
      tv.push_back(mk(4'b0001, 4'b1001, 32'hCAFEF00D, 4'b0000, 0, 0, 1, 2'd0, 6'd18));
      tv.push_back(mk(4'b0001, 4'b0001, 32'hCAFEF00D, 4'b0001, 1, 0, 1, 2'd0, 6'd11));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd0, 6'd36));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd0, 6'd29));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd0, 6'd22));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd0, 6'd15));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 1, 2'd0, 6'd8));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 1, 1, 2'd0, 6'd1));
      tv.push_back(mk(4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 0, 0, 2'd0, 6'd0));

      for (int i = 0; i < N; i++) gap[i] = 0;
      cyc = 0; pkts_done = 0;
      model_reset();
      rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
      repeat (2) @(negedge clk);

      for (int k = 0; k < tv.size(); k++) begin
         @(negedge clk);
         rst = 1'b0;
         req_valid = tv[k].valid;
         req_last  = tv[k].last;
         req_data  = {N{tv[k].data}};
         #1;
         chk($sformatf("v%0d.ready", k), req_ready, tv[k].e_ready);
         chk($sformatf("v%0d.gb_valid", k), gb_valid_in, tv[k].e_gbv);
         if (tv[k].e_gbv) chk($sformatf("v%0d.gb_data", k), gb_data_in, tv[k].data);
         chk($sformatf("v%0d.flush", k), gb_flush, tv[k].e_flush);
         chk($sformatf("v%0d.busy", k), busy, tv[k].e_busy);
         chk($sformatf("v%0d.active", k), active_id, tv[k].e_act);
         chk($sformatf("v%0d.fill", k), fill_level, tv[k].e_fill);
         chk($sformatf("v%0d.err", k), err_timeout, 1'b0);
      end

      // Round-robin order 0,1,3 from a fresh rr pointer.
      tick(1);
      grants.delete();
      push(0, 32'hA0A0A0A0, 1, 0);
      push(1, 32'hB1B1B1B1, 1, 0);
      push(3, 32'hD3D3D3D3, 1, 0);
      run_until_idle(200);
      chk("rr_count", grants.size(), 3);
      if (grants.size() == 3) begin
         chk("rr_first", grants[0], 0);
         chk("rr_second", grants[1], 1);
         chk("rr_third", grants[2], 3);
      end

      // Requester 1 stalls 10 cycles mid-packet; grant must hold and the packet complete.
      grants.delete();
      acc_log.delete();
      push(1, 32'h11110001, 0, 0);
      push(1, 32'h11110002, 0, 10);
      push(1, 32'h11110003, 1, 0);
      run_until_idle(200);
      chk("stall_grants", grants.size(), 1);
      chk("stall_words", acc_log.size(), 3);
      if (acc_log.size() == 3) chk("stall_gap", acc_log[1] - acc_log[0], 11);

      // Reset while draining at fill 18: everything clears and rr restarts at 0.
      push(2, 32'h22222222, 1, 0);
      n = 0;
      while (!(draining && fill_m == 18) && n < 50) begin
         tick(0);
         n++;
      end
      chk("drain_reached", n < 50, 1);
      tick(1);
      chk("pre_rst_fill", fill_level, 18);
      tick(0);
      chk("rst_fill", fill_level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flush", gb_flush, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gbv", gb_valid_in, 0);
      chk("rst_active", active_id, 0);
      grants.delete();
      push(1, 32'h1A1A1A1A, 1, 0);
      push(2, 32'h2A2A2A2A, 1, 0);
      run_until_idle(200);
      chk("rst_rr_count", grants.size(), 2);
      if (grants.size() == 2) chk("rst_rr_first", grants[0], 1);

      // Randomised packets from all requesters against the reference model.
      base = pkts_done;
      npk  = 40;
      for (int p = 0; p < npk; p++) begin
         int r;
         r   = $urandom_range(0, N - 1);
         len = $urandom_range(1, 4);
         for (int w = 0; w < len; w++) begin
            push(r, $urandom, (w == len - 1), (w == 0) ? $urandom_range(0, 6) : $urandom_range(0, 3));
         end
      end
      run_until_idle(20000);
      chk("rand_packets", pkts_done - base, npk);
      chk("rand_queue_empty", wq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gearbox_stream_arbiter.md
Name: gearbox_stream_arbiter

Overview:
- Shares one 32->7 unpacking gearbox between NUM_REQ packetised requesters.
- Round-robin grant, held for a whole packet, so output symbols never mix streams.
- Paces writes into the gearbox with an internal fill-level model, since the gearbox has no backpressure.
- Flushes the gearbox's sub-symbol residue at every packet end.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- IN_WIDTH, 32, requester and gearbox input word width
- OUT_WIDTH, 7, gearbox output symbol width
- GB_CAPACITY, 38, gearbox buffer bits (IN_WIDTH+OUT_WIDTH-1)
- TIMEOUT_CYCLES, 64, stall limit; used only with GBARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*IN_WIDTH  requester words; requester i at [i*IN_WIDTH +: IN_WIDTH]
- req_last  in  NUM_REQ  last word of packet
- req_ready  out  NUM_REQ  word accepted when valid&ready
- gb_valid_in  out  1  word strobe to gearbox
- gb_data_in  out  IN_WIDTH  word to gearbox
- gb_flush  out  1  one-cycle pulse: gearbox discards residual bits
- active_id  out  $clog2(NUM_REQ)  current grant owner; tags gearbox output
- busy  out  1  high in any state other than IDLE
- fill_level  out  $clog2(GB_CAPACITY+1)  modelled gearbox occupancy in bits
- err_timeout  out  1  one-cycle pulse on packet abort (feature only; tied 0 otherwise)

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high on clk/rst.
- Reset values: state=IDLE, rr_ptr=0, fill=0, all outputs 0.

Gearbox model (every cycle):
- emit = (fill >= OUT_WIDTH).
- fill_next = fill + (send ? IN_WIDTH : 0) - (emit ? OUT_WIDTH : 0).
- send_ok = (fill - (emit ? OUT_WIDTH : 0) + IN_WIDTH) <= GB_CAPACITY.
- Compute with one extra bit; fill never exceeds GB_CAPACITY.

Datapath and handshake:
- req_ready[i] = (state==STREAM) & (active_id==i) & send_ok. All other ready bits are 0.
- send = req_valid[active_id] & req_ready[active_id].
- gb_valid_in = send. gb_data_in = req_data slice of active_id, combinational (0 latency).
- Requester must hold valid/data until accepted.

States:
- IDLE:
  - If any req_valid, grant the first requester at or after rr_ptr (cyclic search).
  - Load active_id and go to STREAM next cycle. No word is accepted in IDLE.
- STREAM:
  - Accept words as send_ok allows.
  - On send & req_last, go to DRAIN.
- DRAIN:
  - Wait while the gearbox emits; no requester is ready.
  - When fill < OUT_WIDTH (after the emit), go to FLUSH.
- FLUSH:
  - gb_flush=1 for exactly one cycle; fill<=0.
  - rr_ptr <= active_id+1, wrapping NUM_REQ-1 -> 0; go to IDLE.
  - IDLE may re-grant on the following cycle.

Boundary conditions:
- Single-word packet: the last word is the first send; STREAM -> DRAIN directly.
- Fill exactly OUT_WIDTH: emits (>=), reaching 0 before flush.
- Requester deasserting req_valid mid-packet: grant held indefinitely (unless timeout feature).
- req_last on a non-granted requester: ignored.
- Simultaneous emit and send: both terms apply in the same cycle.
- Reset mid-packet: state, fill and rr_ptr cleared next edge. The gearbox is reset by the same rst; no flush is issued.
- rr_ptr wraps at NUM_REQ-1 -> 0.

Optional Feature:
- Macro GBARB_TIMEOUT_EN.
- Defined:
  - Stall counter runs in STREAM; it counts cycles with req_valid[active_id]=0 and clears on any send.
  - Reaching TIMEOUT_CYCLES: err_timeout pulses one cycle, the packet is aborted, and the state goes to DRAIN then FLUSH as normal. rr_ptr advances past the offender.
- Undefined: no counter; err_timeout tied 0; grant waits forever.

Test Plan:
- Reset, then req_valid[2]=1 with one word 0xDEADBEEF, last=1:
  - gb_valid_in pulses once with that data.
  - fill runs 32,25,18,11,4.
  - gb_flush pulses while fill=4.
  - active_id=2 throughout; busy drops the following cycle.
- Requester 0 sends 2-word packet, valid held:
  - Second word accepted exactly 4 cycles after the first (fill 11 -> 4+32=36 <= 38).
  - fill never exceeds 38.
- Requesters 0,1,3 all valid, rr_ptr=0, 1-word packets each:
  - Grants in order 0,1,3.
  - No gb_valid_in during any DRAIN or FLUSH.
  - req_ready one-hot or zero every cycle.
- Requester 1 drops req_valid for 10 cycles mid-packet:
  - Grant held; no sends in that window; packet completes on resumption.
- Assert rst during DRAIN with fill=18:
  - Next cycle state=IDLE, fill=0, outputs 0, no gb_flush.
  - rr_ptr=0 (grant restarts from 0).
- With GBARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: requester 0 stalls after its first word:
  - err_timeout pulses 8 stalled cycles after the last send, then DRAIN, FLUSH.
  - Next grant goes to requester 1 if valid.
